fetch_stage_ctrl: RTL

//  Consumer of the load-use hazard unit's stall outputs: owns the PC register, the instruction-memory

---
 rtl/fetch_stage_ctrl_if.sv | 33 +++
 rtl/fetch_stage_ctrl.sv | 78 +++++++
 2 files changed

// File: rtl/fetch_stage_ctrl_if.sv
// fetch_stage_ctrl_if: hazard-unit inputs, instruction-memory handshake and IF/ID outputs of the fetch stage.
interface fetch_stage_ctrl_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 16
);
    logic               pc_wr;
    logic               ifid_wr;
    logic               haz_ctrl;
    logic               branch_taken;
    logic [ADDR_W-1:0]  branch_target;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_valid;
    logic [INSTR_W-1:0] ifid_instr;
    logic [ADDR_W-1:0]  ifid_pc_plus4;
    logic               ifid_valid;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;
    logic               protocol_err;

    modport master (
        input  pc_wr, ifid_wr, haz_ctrl, branch_taken, branch_target, imem_rdata, imem_valid,
        output imem_req, imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, stall_cnt, flush_cnt,
               protocol_err
    );
    modport slave (
        output pc_wr, ifid_wr, haz_ctrl, branch_taken, branch_target, imem_rdata, imem_valid,
        input  imem_req, imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, stall_cnt, flush_cnt,
               protocol_err
    );
endinterface

// File: rtl/fetch_stage_ctrl.sv
// fetch_stage_ctrl: PC register, imem fetch handshake and IF/ID register honouring load-use stalls and branch flushes.
module fetch_stage_ctrl #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [INSTR_W-1:0] NOP     = '0,
    parameter int                CNT_W    = 16
) (
    input  logic clk,
    input  logic rst_n,
    fetch_stage_ctrl_if.master bus
);
    typedef enum logic {FETCH, HOLD} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] buf_instr;
    logic [ADDR_W-1:0]  buf_pc_plus4;
    logic               stall;
    logic               perr;
    logic [ADDR_W-1:0]  pc_plus4;

    assign stall         = ~bus.pc_wr | ~bus.ifid_wr;
    assign perr          = (bus.haz_ctrl != ~bus.ifid_wr) | (bus.pc_wr != bus.ifid_wr);
    assign pc_plus4      = pc + ADDR_W'(4);
    assign bus.imem_addr = pc;
    assign bus.imem_req  = rst_n & (state == FETCH);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= FETCH;
            pc                <= {RESET_PC[ADDR_W-1:2], 2'b00};
            buf_instr         <= NOP;
            buf_pc_plus4      <= '0;
            bus.ifid_instr    <= NOP;
            bus.ifid_pc_plus4 <= '0;
            bus.ifid_valid    <= 1'b0;
            bus.stall_cnt     <= '0;
            bus.flush_cnt     <= '0;
            bus.protocol_err  <= 1'b0;
        end else begin
            if (stall && !bus.branch_taken && bus.stall_cnt != '1)
                bus.stall_cnt <= bus.stall_cnt + 1'b1;
            if (perr)
                bus.protocol_err <= 1'b1;
            // A taken branch overrides stall and any word returned this cycle.
            if (bus.branch_taken) begin
                state             <= FETCH;
                pc                <= {bus.branch_target[ADDR_W-1:2], 2'b00};
                bus.ifid_instr    <= NOP;
                bus.ifid_pc_plus4 <= '0;
                bus.ifid_valid    <= 1'b0;
                if (bus.flush_cnt != '1)
                    bus.flush_cnt <= bus.flush_cnt + 1'b1;
            end else if (state == FETCH) begin
                if (bus.imem_valid && !stall) begin
                    bus.ifid_instr    <= bus.imem_rdata;
                    bus.ifid_pc_plus4 <= pc_plus4;
                    bus.ifid_valid    <= 1'b1;
                    pc                <= pc_plus4;
                end else if (bus.imem_valid) begin
                    buf_instr    <= bus.imem_rdata;
                    buf_pc_plus4 <= pc_plus4;
                    state        <= HOLD;
                end else if (!stall) begin
                    bus.ifid_instr <= NOP;
                    bus.ifid_valid <= 1'b0;
                end
            end else if (!stall) begin
                bus.ifid_instr    <= buf_instr;
                bus.ifid_pc_plus4 <= buf_pc_plus4;
                bus.ifid_valid    <= 1'b1;
                pc                <= pc_plus4;
                state             <= FETCH;
            end
        end
    end
endmodule
